vec_inst_issue_queue: RTL and testbench
=======================================

// Module: vec_inst_issue_queue
// PURPOSE
//  Parametrised successor to the single-instruction val/ready controller between scalar core and vector datapath.
//  Buffers up to DEPTH {instruction, rs1_data, rs2_data} packets from the scalar core.
//  Issues them in order, one at a time, to the vector datapath. Waits for inst_done, then returns vec_pro_ack.
//  Lets the scalar core run ahead by DEPTH instructions instead of stalling on every vector op.
// PARAMETERS
//  XLEN   32  width of instruction, rs1_data, rs2_data
//  DEPTH  4   queue entries; power of two, >= 2
// PORTS
//  clk               in   1                 single clock, rising edge
//  reset             in   1                 synchronous, active-high
//  inst_valid        in   1                 scalar core offers a packet
//  instruction       in   XLEN              vector instruction
//  rs1_data          in   XLEN              scalar operand 1
//  rs2_data          in   XLEN              scalar operand 2
//  vec_pro_ready     out  1                 queue can accept a packet this cycle
//  flush             in   1                 drop all queued (not yet issued) packets
//  iss_valid         out  1                 head packet presented to datapath
//  iss_instruction   out  XLEN              head instruction
//  iss_rs1_data      out  XLEN              head rs1
//  iss_rs2_data      out  XLEN              head rs2
//  iss_ready         in   1                 datapath accepts head packet
//  inst_done         in   1                 datapath finished the issued instruction
//  vec_pro_ack       out  1                 completion ack to scalar core
//  scalar_pro_ready  in   1                 scalar core consumes ack
//  q_count           out  $clog2(DEPTH+1)   occupied entries
// BEHAVIOUR
//  Reset (sync): count=0, rd/wr ptr=0, FSM=IDLE; all outputs 0 during and after reset cycle, except vec_pro_ready=1 after.
//  Push: inst_valid && vec_pro_ready -> entry written at wr_ptr, wr_ptr++ (wraps mod DEPTH), count++.
//  vec_pro_ready = (count != DEPTH) && !flush && !reset; combinational from registered count.
//  No full pass-through: push blocked when full even if pop occurs same cycle.
//  Pop: iss_valid && iss_ready -> rd_ptr++ (wraps), count--. Push and pop together -> count unchanged.
//  iss_* data = entry[rd_ptr]; valid only while iss_valid.
//  FSM states:
//   IDLE  -> ISSUE when count != 0.
//   ISSUE -> iss_valid=1, held stable until iss_ready; handshake -> BUSY. Any inst_done in ISSUE is ignored.
//   BUSY  -> wait inst_done (1-cycle pulse); then -> ACK.
//   ACK   -> vec_pro_ack=1, held until scalar_pro_ready. On handshake: -> ISSUE if count != 0, else IDLE.
//  Min latency push->iss_valid: 2 cycles (push at N, count visible N+1, ISSUE at N+2).
//  Exactly one instruction in flight; inst_done outside BUSY is ignored.
//  flush: count=0, rd_ptr=wr_ptr. Push in the same cycle is dropped. Pop in the same cycle is dropped (iss_valid forced 0).
//   Flush has no effect on BUSY/ACK: the in-flight instruction still completes and acks.
//   ISSUE under flush -> IDLE.
//  reset mid-operation: in-flight instruction abandoned, no ack produced.
// CONFIGURATION
//  VIQ_PERF_CNT_EN defined: adds two outputs, both cleared by reset, saturating at all-ones.
//   perf_issued   out 32  counts iss handshakes.
//   perf_stall    out 32  counts cycles with inst_valid=1 && vec_pro_ready=0.
//  VIQ_PERF_CNT_EN undefined: ports and counters absent; all other behaviour identical.
// STRUCTURE
//  Package vec_issue_pkg:
//   typedef viq_entry_t (struct: instruction, rs1_data, rs2_data).
//   typedef viq_state_e (IDLE, ISSUE, BUSY, ACK).
//  XLEN comes from the existing vector_processor_defs.svh.
//  Sub-module viq_fifo: storage array, pointers, count, flush.
//  Top holds the FSM and the optional counters.
// TESTING
//  1 Push A (instruction=0x0000_5057); iss_ready=1; inst_done 3 cycles after issue; scalar_pro_ready=1
//    -> iss_valid at cycle 2, vec_pro_ack one cycle after inst_done, then IDLE.
//  2 Push 4 packets back-to-back, iss_ready=0 (DEPTH=4)
//    -> q_count=4, vec_pro_ready=0; 5th offer not accepted; order A,B,C,D preserved on issue.
//  3 Full queue, one pop and one offered push in the same cycle
//    -> push rejected, q_count 4->3; push accepted next cycle -> 4.
//  4 Hold scalar_pro_ready=0 for 5 cycles in ACK
//    -> vec_pro_ack held high 5 cycles; no new issue until ack handshake.
//  5 BUSY with 2 queued, assert flush
//    -> q_count=0; in-flight instruction still acks; then IDLE, iss_valid stays 0.
//  6 Reset asserted in BUSY
//    -> next cycle all outputs 0, q_count=0; later inst_done yields no ack.
//    With VIQ_PERF_CNT_EN: perf_issued/perf_stall match scenario 2 counts.

Source files
------------

// File: rtl/vec_issue_pkg.sv
// Shared types for the vector instruction issue queue.
// XLEN is fixed here so the queued packet can be a packed struct.
package vec_issue_pkg;

    localparam int unsigned XLEN = 32;

    // One queued packet from the scalar core.
    typedef struct packed {
        logic [XLEN-1:0] instruction;
        logic [XLEN-1:0] rs1_data;
        logic [XLEN-1:0] rs2_data;
    } viq_entry_t;

    // Issue controller states.
    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        BUSY,
        ACK
    } viq_state_e;

endpackage

// File: rtl/vec_inst_issue_queue_if.sv
// Scalar-core / vector-datapath bus for the issue queue.
// The perf counter outputs exist only when VIQ_PERF_CNT_EN is defined.
interface vec_inst_issue_queue_if #(
    parameter int unsigned DEPTH = 4
);
    import vec_issue_pkg::*;

    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic            inst_valid;
    logic [XLEN-1:0] instruction;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic            vec_pro_ready;
    logic            flush;
    logic            iss_valid;
    logic [XLEN-1:0] iss_instruction;
    logic [XLEN-1:0] iss_rs1_data;
    logic [XLEN-1:0] iss_rs2_data;
    logic            iss_ready;
    logic            inst_done;
    logic            vec_pro_ack;
    logic            scalar_pro_ready;
    logic [CW-1:0]   q_count;
`ifdef VIQ_PERF_CNT_EN
    logic [31:0]     perf_issued;
    logic [31:0]     perf_stall;
`endif

    // Driver side: scalar core plus vector datapath.
    modport master (
        output inst_valid, instruction, rs1_data, rs2_data, flush,
        output iss_ready, inst_done, scalar_pro_ready,
`ifdef VIQ_PERF_CNT_EN
        input  perf_issued, perf_stall,
`endif
        input  vec_pro_ready, iss_valid, iss_instruction, iss_rs1_data, iss_rs2_data,
        input  vec_pro_ack, q_count
    );

    // Queue side.
    modport slave (
        input  inst_valid, instruction, rs1_data, rs2_data, flush,
        input  iss_ready, inst_done, scalar_pro_ready,
`ifdef VIQ_PERF_CNT_EN
        output perf_issued, perf_stall,
`endif
        output vec_pro_ready, iss_valid, iss_instruction, iss_rs1_data, iss_rs2_data,
        output vec_pro_ack, q_count
    );

endinterface

// File: rtl/viq_fifo.sv
// Packet storage for the issue queue: circular buffer with occupancy count.
// push/pop arrive already qualified; flush empties the queue in one cycle.
module viq_fifo
    import vec_issue_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         push,
    input  logic                         pop,
    input  logic                         flush,
    input  viq_entry_t                   wdata,
    output viq_entry_t                   rdata,
    output logic [$clog2(DEPTH+1)-1:0]   count
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    viq_entry_t    mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q;

    // Storage write; contents need no reset since reads are gated by state.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= wdata;
    end

    // Pointers and count; pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush) begin
            rd_ptr_q <= wr_ptr_q;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            count_q <= count_q + CW'(push) - CW'(pop);
        end
    end

    assign rdata = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/vec_inst_issue_queue.sv
// In-order vector instruction issue queue: buffers DEPTH packets and issues
// one at a time, waiting for inst_done and an ack handshake before the next.
// Optional perf counters enabled by VIQ_PERF_CNT_EN.
module vec_inst_issue_queue
    import vec_issue_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input logic                     clk,
    input logic                     reset,
    vec_inst_issue_queue_if.slave   bus
);
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FullCnt = CW'(DEPTH);

    viq_state_e    state_q, state_d;
    logic [CW-1:0] count;
    viq_entry_t    wdata, rdata;
    logic          ready, push, pop, iss_valid, not_empty;

    // No pass-through when full: ready looks only at the registered count.
    assign ready     = (count != FullCnt) && !bus.flush && !reset;
    assign push      = bus.inst_valid && ready;
    assign iss_valid = (state_q == ISSUE) && !bus.flush && !reset;
    assign pop       = iss_valid && bus.iss_ready;
    assign not_empty = (count != '0) && !bus.flush;

    assign wdata = '{instruction: bus.instruction, rs1_data: bus.rs1_data,
                     rs2_data: bus.rs2_data};

    viq_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .flush (bus.flush),
        .wdata (wdata),
        .rdata (rdata),
        .count (count)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // FSM next state; flush only affects the not-yet-issued head.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:  if (not_empty) state_d = ISSUE;
            ISSUE: begin
                if (bus.flush)          state_d = IDLE;
                else if (bus.iss_ready) state_d = BUSY;
            end
            BUSY:  if (bus.inst_done) state_d = ACK;
            ACK:   if (bus.scalar_pro_ready) state_d = not_empty ? ISSUE : IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign bus.vec_pro_ready   = ready;
    assign bus.iss_valid       = iss_valid;
    assign bus.iss_instruction = iss_valid ? rdata.instruction : '0;
    assign bus.iss_rs1_data    = iss_valid ? rdata.rs1_data    : '0;
    assign bus.iss_rs2_data    = iss_valid ? rdata.rs2_data    : '0;
    assign bus.vec_pro_ack     = (state_q == ACK) && !reset;
    assign bus.q_count         = reset ? '0 : count;

`ifdef VIQ_PERF_CNT_EN
    logic [31:0] perf_issued_q, perf_stall_q;

    // Saturating counters for issue handshakes and back-pressured offers.
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_issued_q <= '0;
            perf_stall_q  <= '0;
        end else begin
            if (pop && (perf_issued_q != '1)) perf_issued_q <= perf_issued_q + 32'd1;
            if (bus.inst_valid && !ready && (perf_stall_q != '1))
                perf_stall_q <= perf_stall_q + 32'd1;
        end
    end

    assign bus.perf_issued = perf_issued_q;
    assign bus.perf_stall  = perf_stall_q;
`endif

endmodule

// File: tb/tb_vec_inst_issue_queue.sv
// Directed, table-driven bench for vec_inst_issue_queue (DEPTH=4).
// Each row drives one cycle's inputs at negedge and checks outputs 1ns later.
module tb_vec_inst_issue_queue;
    import vec_issue_pkg::*;

    localparam int unsigned DEPTH = 4;
    localparam logic [31:0] K1 = 32'h1111_1111;
    localparam logic [31:0] K2 = 32'h2222_2222;
    localparam logic [31:0] PA = 32'h0000_5057;
    localparam logic [31:0] P1 = 32'h0000_1001;
    localparam logic [31:0] P2 = 32'h0000_1002;
    localparam logic [31:0] P3 = 32'h0000_1003;
    localparam logic [31:0] P4 = 32'h0000_1004;
    localparam logic [31:0] P5 = 32'h0000_1005;
    localparam logic [31:0] Q1 = 32'h0000_2001;
    localparam logic [31:0] Q2 = 32'h0000_2002;
    localparam logic [31:0] Q3 = 32'h0000_2003;
    localparam logic [31:0] R1 = 32'h0000_3001;
    localparam logic [31:0] R2 = 32'h0000_3002;
    localparam logic [31:0] R3 = 32'h0000_3003;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    vec_inst_issue_queue_if #(.DEPTH(DEPTH)) bus ();

    vec_inst_issue_queue #(
        .DEPTH (DEPTH)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic        rst;
        logic        vld;
        logic [31:0] ins;
        logic        fl;
        logic        ir;
        logic        done;
        logic        spr;
        logic        e_vpr;
        logic        e_iv;
        logic [31:0] e_ins;
        logic        e_ack;
        int          e_cnt;
    } vec_t;

    vec_t tbl[$];
    int   errors = 0;
    int   checks = 0;

    function automatic vec_t mk(input logic rst, vld, input logic [31:0] ins,
                                input logic fl, ir, done, spr, e_vpr, e_iv,
                                input logic [31:0] e_ins, input logic e_ack, input int e_cnt);
        vec_t v;
        v.rst = rst; v.vld = vld; v.ins = ins; v.fl = fl; v.ir = ir; v.done = done;
        v.spr = spr; v.e_vpr = e_vpr; v.e_iv = e_iv; v.e_ins = e_ins; v.e_ack = e_ack;
        v.e_cnt = e_cnt;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic apply(input vec_t v, input string tag);
        @(negedge clk);
        reset                = v.rst;
        bus.inst_valid       = v.vld;
        bus.instruction      = v.ins;
        bus.rs1_data         = v.ins ^ K1;
        bus.rs2_data         = v.ins ^ K2;
        bus.flush            = v.fl;
        bus.iss_ready        = v.ir;
        bus.inst_done        = v.done;
        bus.scalar_pro_ready = v.spr;
        #1;
        check({tag, " vec_pro_ready"}, 32'(bus.vec_pro_ready), 32'(v.e_vpr));
        check({tag, " iss_valid"}, 32'(bus.iss_valid), 32'(v.e_iv));
        check({tag, " iss_instruction"}, bus.iss_instruction, v.e_ins);
        check({tag, " iss_rs1_data"}, bus.iss_rs1_data, v.e_iv ? (v.e_ins ^ K1) : 32'h0);
        check({tag, " iss_rs2_data"}, bus.iss_rs2_data, v.e_iv ? (v.e_ins ^ K2) : 32'h0);
        check({tag, " vec_pro_ack"}, 32'(bus.vec_pro_ack), 32'(v.e_ack));
        check({tag, " q_count"}, 32'(bus.q_count), 32'(v.e_cnt));
    endtask

    initial begin
        reset = 1'b1;
        bus.inst_valid = 1'b0; bus.instruction = '0; bus.rs1_data = '0; bus.rs2_data = '0;
        bus.flush = 1'b0; bus.iss_ready = 1'b0; bus.inst_done = 1'b0;
        bus.scalar_pro_ready = 1'b0;

        //             rst vld ins fl ir dn spr | vpr iv ins ack cnt
        // Single packet: reset, push, issue 2 cycles later, done, ack, idle.
        tbl.push_back(mk(1, 0, 0,  0, 0, 0, 0,   0, 0, 0,  0, 0));
        tbl.push_back(mk(0, 1, PA, 0, 1, 0, 1,   1, 0, 0,  0, 0));
        tbl.push_back(mk(0, 0, 0,  0, 1, 0, 1,   1, 0, 0,  0, 1));
        tbl.push_back(mk(0, 0, 0,  0, 1, 0, 1,   1, 1, PA, 0, 1));
        tbl.push_back(mk(0, 0, 0,  0, 1, 0, 1,   1, 0, 0,  0, 0));
        tbl.push_back(mk(0, 0, 0,  0, 1, 0, 1,   1, 0, 0,  0, 0));
        tbl.push_back(mk(0, 0, 0,  0, 1, 1, 1,   1, 0, 0,  0, 0));
        tbl.push_back(mk(0, 0, 0,  0, 1, 0, 1,   1, 0, 0,  1, 0));
        tbl.push_back(mk(0, 0, 0,  0, 1, 0, 1,   1, 0, 0,  0, 0));
        // Fill to full with iss_ready low; 5th offer refused.
        tbl.push_back(mk(0, 1, P1, 0, 0, 0, 1,   1, 0, 0,  0, 0));
        tbl.push_back(mk(0, 1, P2, 0, 0, 0, 1,   1, 0, 0,  0, 1));
        tbl.push_back(mk(0, 1, P3, 0, 0, 0, 1,   1, 1, P1, 0, 2));
        tbl.push_back(mk(0, 1, P4, 0, 0, 0, 1,   1, 1, P1, 0, 3));
        tbl.push_back(mk(0, 1, P5, 0, 0, 0, 1,   0, 1, P1, 0, 4));
        // Full: pop with offered push -> push refused, 4->3; retried push accepted.
        tbl.push_back(mk(0, 1, P5, 0, 1, 0, 1,   0, 1, P1, 0, 4));
        tbl.push_back(mk(0, 1, P5, 0, 1, 0, 1,   1, 0, 0,  0, 3));
        tbl.push_back(mk(0, 0, 0,  0, 1, 1, 1,   0, 0, 0,  0, 4));
        tbl.push_back(mk(0, 0, 0,  0, 1, 0, 1,   0, 0, 0,  1, 4));
        // Drain in order P2, P3, P4.
        tbl.push_back(mk(0, 0, 0,  0, 1, 0, 1,   0, 1, P2, 0, 4));
        tbl.push_back(mk(0, 0, 0,  0, 1, 1, 1,   1, 0, 0,  0, 3));
        tbl.push_back(mk(0, 0, 0,  0, 1, 0, 1,   1, 0, 0,  1, 3));
        tbl.push_back(mk(0, 0, 0,  0, 1, 0, 1,   1, 1, P3, 0, 3));
        tbl.push_back(mk(0, 0, 0,  0, 1, 1, 1,   1, 0, 0,  0, 2));
        tbl.push_back(mk(0, 0, 0,  0, 1, 0, 1,   1, 0, 0,  1, 2));
        tbl.push_back(mk(0, 0, 0,  0, 1, 0, 1,   1, 1, P4, 0, 2));
        // Ack held off 5 cycles: no new issue meanwhile.
        tbl.push_back(mk(0, 0, 0,  0, 1, 1, 0,   1, 0, 0,  0, 1));
        for (int k = 0; k < 5; k++) tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 1, 1));
        tbl.push_back(mk(0, 0, 0,  0, 1, 0, 1,   1, 0, 0,  1, 1));
        tbl.push_back(mk(0, 0, 0,  0, 1, 0, 1,   1, 1, P5, 0, 1));

        for (int i = 0; i < tbl.size(); i++) apply(tbl[i], $sformatf("row%0d", i));

`ifdef VIQ_PERF_CNT_EN
        @(posedge clk); #1;
        check("perf_issued", bus.perf_issued, 32'd6);
        check("perf_stall", bus.perf_stall, 32'd2);
`endif

        // Flush while BUSY with two queued: in-flight one still acks.
        apply(mk(0, 1, Q1, 0, 0, 0, 0, 1, 0, 0, 0, 0), "flush_busy0");
        apply(mk(0, 1, Q2, 0, 0, 0, 0, 1, 0, 0, 0, 1), "flush_busy1");
        apply(mk(0, 1, Q3, 1, 0, 0, 0, 0, 0, 0, 0, 2), "flush_busy2");
        apply(mk(0, 0, 0,  0, 0, 1, 0, 1, 0, 0, 0, 0), "flush_busy3");
        apply(mk(0, 0, 0,  0, 0, 0, 1, 1, 0, 0, 1, 0), "flush_busy4");
        apply(mk(0, 0, 0,  0, 1, 0, 1, 1, 0, 0, 0, 0), "flush_busy5");
        // Flush in ISSUE: handshake suppressed, back to IDLE.
        apply(mk(0, 1, R1, 0, 0, 0, 1, 1, 0, 0, 0, 0), "flush_issue0");
        apply(mk(0, 0, 0,  0, 0, 0, 1, 1, 0, 0, 0, 1), "flush_issue1");
        apply(mk(0, 0, 0,  1, 1, 0, 1, 0, 0, 0, 0, 1), "flush_issue2");
        apply(mk(0, 0, 0,  0, 1, 0, 1, 1, 0, 0, 0, 0), "flush_issue3");
        // Reset in BUSY: everything cleared, late inst_done gives no ack.
        apply(mk(0, 1, R2, 0, 0, 0, 1, 1, 0, 0,  0, 0), "rst_busy0");
        apply(mk(0, 0, 0,  0, 0, 0, 1, 1, 0, 0,  0, 1), "rst_busy1");
        apply(mk(0, 0, 0,  0, 1, 0, 1, 1, 1, R2, 0, 1), "rst_busy2");
        apply(mk(0, 1, R3, 0, 0, 0, 1, 1, 0, 0,  0, 0), "rst_busy3");
        apply(mk(1, 0, 0,  0, 0, 0, 1, 0, 0, 0,  0, 0), "rst_busy4");
        apply(mk(0, 0, 0,  0, 0, 1, 1, 1, 0, 0,  0, 0), "rst_busy5");
`ifdef VIQ_PERF_CNT_EN
        check("perf_issued_after_reset", bus.perf_issued, 32'd0);
        check("perf_stall_after_reset", bus.perf_stall, 32'd0);
`endif
        apply(mk(0, 0, 0,  0, 0, 0, 1, 1, 0, 0,  0, 0), "rst_busy6");
        apply(mk(0, 0, 0,  0, 0, 0, 1, 1, 0, 0,  0, 0), "rst_busy7");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
